stream_src_unit: RTL
====================

Name: stream_src_unit

Overview:
- Datapath source unit: the producer end of the `in0`/`out0` unit stream consumed by elementwise units such as the ReLU unit.
- Holds a small local buffer loaded through a write port.
- On a `run` pulse, replays buffer contents on `out0` (one word per enabled cycle) using a two-level address generator: an inner period loop and an outer iteration loop.
- Obeys the same `running` stall semantics as downstream units, so it can feed them directly.

Parameters:
DATA_W, 32, stream and buffer word width
ADDR_W, 6, buffer address width; DEPTH = 2**ADDR_W
CNT_W, 16, width of period/iteration counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
running  in  1  global enable; 0 freezes all sequencing and outputs
run  in  1  single-cycle start pulse, sampled only when running=1
ld_en  in  1  buffer write enable (independent of running)
ld_addr  in  ADDR_W  buffer write address
ld_data  in  DATA_W  buffer write data
cfg_start  in  ADDR_W  first address of the pattern
cfg_incr  in  ADDR_W  address step inside a period
cfg_period  in  CNT_W  words per iteration
cfg_shift  in  ADDR_W  start-address offset added per iteration
cfg_iter  in  CNT_W  number of iterations
out0  out  DATA_W  stream output word
out_valid  out  1  out0 carries a new word this cycle
done  out  1  high from pattern completion until the next run or reset

Behaviour:
- Reset (async, rst=1): state=IDLE, out0=0, out_valid=0, done=0, all counters 0. Buffer contents are not reset.
- Loading:
  - ld_en=1 writes ld_data to buf[ld_addr] at posedge, in any state and regardless of running.
  - Same-cycle read and write of one address returns the old data (read-before-write).
- States: IDLE, RUN, DONE.
  - IDLE/DONE + run=1 + running=1:
    - Latch cfg_* into shadow registers; addr=cfg_start, base=cfg_start, pcnt=0, icnt=0, done=0.
    - Go to RUN, or to DONE if latched period==0 or iter==0; done=1 the next cycle and no word is emitted.
  - RUN, running=1, each cycle:
    - Issue read of buf[addr].
    - If pcnt==period-1: pcnt=0, icnt++, base+=shift, addr=base+shift.
    - Otherwise: pcnt++, addr+=incr.
    - After the read for (pcnt==period-1 and icnt==iter-1): go to DONE.
  - RUN + run=1: restart with freshly latched config, same as the IDLE case. The in-flight read word still emerges.
  - running=0: state, counters and addr hold; the pending read is held; out0 holds its value; out_valid=0.
- Latency:
  - out0 is registered; the word read in enabled cycle N appears at cycle N+1 with out_valid=1.
  - If running drops at N+1, the word presents on the next cycle with running=1.
- Address arithmetic: all address sums are modulo DEPTH (wrap without error).
- Completion timing:
  - done rises in the same cycle the last out_valid word is presented.
  - done stays high in DONE; cleared by run or rst.
- Output hold: out0 keeps its last word in IDLE/DONE.
- Reset mid-RUN: immediate abort; outputs return to reset values asynchronously.

Decomposition:
- Package stream_src_pkg:
  - state enum (IDLE/RUN/DONE)
  - default width localparams
  - config record struct {start, incr, period, shift, iter} for shadow registers
- Sub-module src_buf: DEPTH x DATA_W, 1 write port, 1 registered read port with read-enable (hold when re=0), read-before-write. Maps to BRAM/LUTRAM.

Test Plan:
- Reset: rst high 2 cycles, then low -> out0=0, out_valid=0, done=0.
- Linear:
  - Stimulus: load buf[i]=i+100 for i=0..7; start=2, incr=1, period=4, shift=0, iter=1; run.
  - Response: out_valid words 102,103,104,105 on consecutive cycles; done rises with 105.
- 2-D with wrap:
  - Stimulus: DEPTH=64, buf[i]=i; start=62, incr=1, period=3, shift=8, iter=2.
  - Response: 62,63,0 then 6,7,8; done after 8.
- Stall:
  - Stimulus: during the linear case, drop running for 3 cycles after word 103.
  - Response: out_valid=0 and out0 holds 103 for those cycles; then 104,105 with no loss or duplication.
- Degenerate and restart:
  - period=0 -> done=1 one cycle after run, no out_valid.
  - run re-pulsed mid-pattern with start=0 -> one in-flight word, then the sequence from buf[0].
- Load collision and reset:
  - Write buf[3]=0xDEAD in the same cycle it is read (old value 103) -> 103 emitted; a later pattern reads 0xDEAD.
  - Assert rst mid-RUN -> outputs 0 immediately.

Source files
------------

// File: rtl/stream_src_pkg.sv
// Shared types for the stream source unit: FSM states, default widths and the
// shadow-register record that holds the latched pattern configuration.
package stream_src_pkg;

    localparam int SRC_DATA_W = 32;
    localparam int SRC_ADDR_W = 6;
    localparam int SRC_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } src_state_e;

    typedef struct packed {
        logic [SRC_ADDR_W-1:0] start;
        logic [SRC_ADDR_W-1:0] incr;
        logic [SRC_CNT_W-1:0]  period;
        logic [SRC_ADDR_W-1:0] shift;
        logic [SRC_CNT_W-1:0]  iter;
    } src_cfg_t;

    // A pattern with no words completes without ever entering RUN.
    function automatic logic cfg_is_empty(input src_cfg_t cfg);
        return (cfg.period == '0) || (cfg.iter == '0);
    endfunction

endpackage

// File: rtl/stream_src_buf.sv
// Local pattern buffer: one write port and one registered, enable-gated read
// port with read-before-write behaviour on a same-address collision.
module src_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = mem_q[rd_addr];
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values; that is also what gives read-before-write here.
    // NOTE: the array and its read register are deliberately not reset so they map onto block/distributed RAM;
    //       the consumer qualifies rd_data with its own reset valid flag.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_q <= rd_d;
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/stream_src_unit.sv
// Stream source: replays buffer contents on out0 using a two-level
// (period x iteration) address pattern, stalled by the global running enable.
module stream_src_unit
    import stream_src_pkg::*;
#(
    parameter int DATA_W = SRC_DATA_W,
    parameter int ADDR_W = SRC_ADDR_W,
    parameter int CNT_W  = SRC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              running,
    input  logic              run,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] cfg_start,
    input  logic [ADDR_W-1:0] cfg_incr,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [ADDR_W-1:0] cfg_shift,
    input  logic [CNT_W-1:0]  cfg_iter,
    output logic [DATA_W-1:0] out0,
    output logic              out_valid,
    output logic              done
);

    // The shadow record is sized by the package, so the address/counter widths must agree with it.
    if ((ADDR_W != SRC_ADDR_W) || (CNT_W != SRC_CNT_W)) begin : g_width_check
        $error("stream_src_unit: ADDR_W/CNT_W must match stream_src_pkg widths");
    end

    src_state_e        state_q, state_d;
    src_cfg_t          cfg_q, cfg_d, cfg_in;
    logic [ADDR_W-1:0] row_off_q, row_off_d;
    logic [ADDR_W-1:0] col_off_q, col_off_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  period_last;
    logic [CNT_W-1:0]  iter_last;

    assign cfg_in = '{start:  cfg_start,
                      incr:   cfg_incr,
                      period: cfg_period,
                      shift:  cfg_shift,
                      iter:   cfg_iter};

    // Offsets are kept relative to start; the ADDR_W-wide sum wraps modulo DEPTH for free.
    assign rd_addr     = cfg_q.start + row_off_q + col_off_q;
    assign period_last = cfg_q.period - CNT_W'(1);
    assign iter_last   = cfg_q.iter - CNT_W'(1);

    src_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .we      (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .re      (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        row_off_d = row_off_q;
        col_off_d = col_off_q;
        pcnt_d    = pcnt_q;
        icnt_d    = icnt_q;
        vld_d     = vld_q;
        done_d    = done_q;
        hold_d    = hold_q;
        rd_en     = 1'b0;

        if (running) begin
            // A pending word is consumed in this cycle, so it becomes the held value.
            vld_d = 1'b0;
            if (vld_q) begin
                hold_d = rd_data;
            end

            // In RUN the read is issued even on a restart cycle: that word still emerges.
            if (state_q == ST_RUN) begin
                rd_en = 1'b1;
                vld_d = 1'b1;
            end

            if (run) begin
                cfg_d     = cfg_in;
                row_off_d = '0;
                col_off_d = '0;
                pcnt_d    = '0;
                icnt_d    = '0;
                if (cfg_is_empty(cfg_in)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    done_d  = 1'b0;
                end
            end else if (state_q == ST_RUN) begin
                if (pcnt_q == period_last) begin
                    pcnt_d    = '0;
                    icnt_d    = icnt_q + CNT_W'(1);
                    row_off_d = row_off_q + cfg_q.shift;
                    col_off_d = '0;
                    if (icnt_q == iter_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    pcnt_d    = pcnt_q + CNT_W'(1);
                    col_off_d = col_off_q + cfg_q.incr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            row_off_q <= '0;
            col_off_q <= '0;
            pcnt_q    <= '0;
            icnt_q    <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            row_off_q <= row_off_d;
            col_off_q <= col_off_d;
            pcnt_q    <= pcnt_d;
            icnt_q    <= icnt_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            hold_q    <= hold_d;
        end
    end

    // A stalled pending word is withheld; done waits until the last word is actually presented.
    assign out_valid = vld_q & running;
    assign out0      = out_valid ? rd_data : hold_q;
    assign done      = done_q & ~(vld_q & ~running);

endmodule
